// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment driver: segment bit positions and hex glyphs.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high glyphs, bit SEG_A = a ... bit SEG_G = g; b and d are lowercase.
    localparam logic [6:0] HEX_GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg_hex7.sv
// Combinational nibble to seven-segment glyph decoder (active-high, a..g).
module seg_hex7 (
    input  logic [3:0] nib,
    output logic [6:0] glyph
);
    import seg_pkg::*;

    assign glyph = HEX_GLYPH[nib];

endmodule

// File: rtl/seg_mux_drv.sv
// Multiplexed seven-segment scanner with tear-free LOAD/READY updates committed at frame wrap.
// Define SEG_DIM_EN to gate each slot's on-time by the BRIGHT level.
module seg_mux_drv #(
    parameter int NDIG        = 4,
    parameter int SCAN_DIV    = 1024,
    parameter int GUARD       = 4,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [4*NDIG-1:0] D,
    input  logic [NDIG-1:0]   DP,
    input  logic [NDIG-1:0]   BLANK,
    input  logic              LZB,
    input  logic [3:0]        BRIGHT,
    input  logic              LOAD,
    output logic              READY,
    output logic              FRAME,
    output logic [7:0]        SEG,
    output logic [NDIG-1:0]   DIGIT
);
    import seg_pkg::*;

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);
    localparam logic [DIVW-1:0] GUARD_V  = DIVW'(GUARD);
    localparam logic [7:0]      SEG_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NDIG-1:0] DIG_OFF  = (DIG_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [DIVW-1:0]   div;
    logic [IDXW-1:0]   idx;
    logic              frame_q;
    logic              slot_end;
    logic              frame_end;

    logic              pend;
    logic [4*NDIG-1:0] pend_d;
    logic [NDIG-1:0]   pend_dp;
    logic [NDIG-1:0]   pend_blank;
    logic              pend_lzb;
    logic [4*NDIG-1:0] disp_d;
    logic [NDIG-1:0]   disp_dp;
    logic [NDIG-1:0]   disp_blank;
    logic              disp_lzb;

    logic [NDIG-1:0]   lz_dark;
    logic              allz;
    logic [NDIG-1:0]   dark_vec;
    logic [3:0]        nib;
    logic [6:0]        glyph;
    logic              lit;
    logic              on;
    logic [7:0]        seg_next;
    logic [NDIG-1:0]   dig_next;
    logic [7:0]        seg_p1;
    logic [NDIG-1:0]   dig_p1;

    assign slot_end  = (div == DIV_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div     <= '0;
            idx     <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_end;
            if (slot_end) begin
                div <= '0;
                idx <= frame_end ? '0 : idx + 1'b1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // A LOAD coinciding with the wrap keeps pend set while the older value commits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend       <= 1'b0;
            disp_blank <= '1;
        end else begin
            if (frame_end && pend)
                disp_blank <= pend_blank;
            if (LOAD)
                pend <= 1'b1;
            else if (frame_end)
                pend <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (LOAD) begin
            pend_d     <= D;
            pend_dp    <= DP;
            pend_blank <= BLANK;
            pend_lzb   <= LZB;
        end
        if (frame_end && pend) begin
            disp_d   <= pend_d;
            disp_dp  <= pend_dp;
            disp_lzb <= pend_lzb;
        end
    end

    always_comb begin
        allz    = 1'b1;
        lz_dark = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            allz = allz && (disp_d[4*i +: 4] == 4'h0);
            if (i != 0)
                lz_dark[i] = allz;
        end
    end

    assign dark_vec = disp_blank | (disp_lzb ? lz_dark : '0);
    assign nib      = disp_d[{idx, 2'b00} +: 4];

    seg_hex7 u_hex7 (
        .nib   (nib),
        .glyph (glyph)
    );

`ifdef SEG_DIM_EN
    logic [DIVW:0] dim_end;

    function automatic logic [DIVW:0] dim_limit(input logic [3:0] b);
        int len;
        len = ((int'(b) + 1) * (SCAN_DIV - GUARD)) / 16;
        return (DIVW + 1)'(GUARD + len);
    endfunction

    // Latched at slot end so a BRIGHT change never truncates a slot already running.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            dim_end <= (DIVW + 1)'(SCAN_DIV);
        else if (slot_end)
            dim_end <= dim_limit(BRIGHT);
    end

    assign lit = ({1'b0, div} < dim_end);
`else
    logic unused_bright;
    assign unused_bright = ^BRIGHT;
    assign lit = 1'b1;
`endif

    always_comb begin
        on       = (div >= GUARD_V) && lit;
        seg_next = 8'h00;
        dig_next = '0;
        if (on) begin
            dig_next = NDIG'(1) << idx;
            if (!dark_vec[idx]) begin
                seg_next[SEG_G:SEG_A] = glyph;
                seg_next[SEG_DP]      = disp_dp[idx];
            end
        end
    end

    // Output stage: polarity applied after all gating.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            seg_p1 <= SEG_OFF;
            dig_p1 <= DIG_OFF;
        end else begin
            seg_p1 <= seg_next ^ SEG_OFF;
            dig_p1 <= dig_next ^ DIG_OFF;
        end
    end

    assign SEG   = seg_p1;
    assign DIGIT = dig_p1;
    assign READY = !pend;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_mux_drv.sv
// Self-checking bench for seg_mux_drv: directed scenarios plus randomized scan checked against a frame-level model.
module tb_seg_mux_drv;

    localparam int NDIG      = 4;
    localparam int SCAN_DIV  = 1024;
    localparam int GUARD     = 4;
    localparam int FRAME_LEN = NDIG * SCAN_DIV;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] D = 16'h0;
    logic [3:0]  DP = 4'h0;
    logic [3:0]  BLANK = 4'h0;
    logic        LZB = 1'b0;
    logic [3:0]  BRIGHT = 4'hF;
    logic        LOAD = 1'b0;
    logic        READY;
    logic        FRAME;
    logic [7:0]  SEG;
    logic [3:0]  DIGIT;

    int vectors = 0;
    int errors  = 0;

    seg_mux_drv #(
        .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .D(D), .DP(DP), .BLANK(BLANK), .LZB(LZB),
        .BRIGHT(BRIGHT), .LOAD(LOAD), .READY(READY), .FRAME(FRAME), .SEG(SEG), .DIGIT(DIGIT)
    );

    always #5 CLK = ~CLK;

    // Reference model: position within the frame as a single cycle count.
    int          m_cnt;
    logic        m_pend;
    logic [15:0] m_pd, m_dd;
    logic [3:0]  m_pdp, m_ddp, m_pbl, m_dbl;
    logic        m_plz, m_dlz;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_ready, exp_frame;
`ifdef SEG_DIM_EN
    logic [3:0]  m_bright;
`endif

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic m_lit(input int cnt);
        int pos;
        pos = cnt % SCAN_DIV;
        m_lit = (pos >= GUARD);
`ifdef SEG_DIM_EN
        if (pos >= GUARD + ((int'(m_bright) + 1) * (SCAN_DIV - GUARD)) / 16)
            m_lit = 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_digit(input int cnt);
        if (!m_lit(cnt))
            return 4'hF;
        return ~(4'b0001 << (cnt / SCAN_DIV));
    endfunction

    function automatic logic [7:0] m_segs(input int cnt);
        int s;
        logic dark;
        s = cnt / SCAN_DIV;
        dark = m_dbl[s] || (m_dlz && s != 0 && (m_dd >> (4 * s)) == 16'h0);
        if (!m_lit(cnt) || dark)
            return 8'hFF;
        return ~{m_ddp[s], hex_glyph(m_dd[4*s +: 4])};
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_cnt     <= 0;
            m_pend    <= 1'b0;
            m_dd      <= 16'h0;
            m_ddp     <= 4'h0;
            m_dbl     <= 4'hF;
            m_dlz     <= 1'b0;
            exp_seg   <= 8'hFF;
            exp_dig   <= 4'hF;
            exp_ready <= 1'b1;
            exp_frame <= 1'b0;
`ifdef SEG_DIM_EN
            m_bright  <= 4'hF;
`endif
        end else begin
            exp_seg   <= m_segs(m_cnt);
            exp_dig   <= m_digit(m_cnt);
            exp_frame <= (m_cnt == FRAME_LEN - 1);
`ifdef SEG_DIM_EN
            if (m_cnt % SCAN_DIV == SCAN_DIV - 1)
                m_bright <= BRIGHT;
`endif
            if (m_cnt == FRAME_LEN - 1 && m_pend) begin
                m_dd  <= m_pd;
                m_ddp <= m_pdp;
                m_dbl <= m_pbl;
                m_dlz <= m_plz;
            end
            if (LOAD) begin
                m_pd  <= D;
                m_pdp <= DP;
                m_pbl <= BLANK;
                m_plz <= LZB;
            end
            m_pend    <= LOAD || (m_pend && m_cnt != FRAME_LEN - 1);
            exp_ready <= !(LOAD || (m_pend && m_cnt != FRAME_LEN - 1));
            m_cnt     <= (m_cnt + 1) % FRAME_LEN;
        end
    end

    task automatic drive_load(input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] bl, input logic lz);
        D = d; DP = dp; BLANK = bl; LZB = lz; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (FRAME !== 1'b1 && n < 2 * FRAME_LEN);
        vectors++;
        if (FRAME !== 1'b1) begin
            errors++;
            $display("FAIL frame_timeout FRAME=%b required 1 after %0d cycles", FRAME, n);
        end
    endtask

    task automatic test_reset();
        int n;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (1000) @(negedge CLK);
        drive_load(16'h8888, 4'h0, 4'h0, 1'b0);
        repeat (500) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        vectors++;
        if (SEG !== 8'hFF || DIGIT !== 4'hF || READY !== 1'b1 || FRAME !== 1'b0) begin
            errors++;
            $display("FAIL reset_async SEG=%h DIGIT=%b READY=%b FRAME=%b required FF/1111/1/0",
                     SEG, DIGIT, READY, FRAME);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (FRAME !== 1'b1 && n < FRAME_LEN + 100);
        vectors++;
        if (n != FRAME_LEN) begin
            errors++;
            $display("FAIL reset_first_frame at %0d cycles required %0d", n, FRAME_LEN);
        end
    endtask

    task automatic test_load_display();
        logic [7:0] es [4];
        logic [3:0] ed;
        es = '{8'h8E, 8'h08, 8'hA4, 8'hF9};
        drive_load(16'h12AF, 4'b0010, 4'h0, 1'b0);
        vectors++;
        if (READY !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_low READY=%b required 0", READY);
        end
        sync_frame();
        vectors++;
        if (READY !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_high READY=%b required 1", READY);
        end
        for (int s = 0; s < NDIG; s++) begin
            repeat (s == 0 ? 513 : SCAN_DIV) @(negedge CLK);
            ed = ~(4'b0001 << s);
            vectors++;
            if (SEG !== es[s] || DIGIT !== ed) begin
                errors++;
                $display("FAIL load_digit%0d SEG=%h DIGIT=%b required %h/%b", s, SEG, DIGIT, es[s], ed);
            end
        end
    endtask

    task automatic test_lzb();
        logic [7:0] es [4];
        logic [3:0] ed;
        drive_load(16'h0050, 4'b1100, 4'h0, 1'b1);
        sync_frame();
        es = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
        for (int s = 0; s < NDIG; s++) begin
            repeat (s == 0 ? 513 : SCAN_DIV) @(negedge CLK);
            ed = ~(4'b0001 << s);
            vectors++;
            if (SEG !== es[s] || DIGIT !== ed) begin
                errors++;
                $display("FAIL lzb_0050_digit%0d SEG=%h DIGIT=%b required %h/%b", s, SEG, DIGIT, es[s], ed);
            end
        end
        drive_load(16'h0000, 4'h0, 4'h0, 1'b1);
        sync_frame();
        es = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        for (int s = 0; s < NDIG; s++) begin
            repeat (s == 0 ? 513 : SCAN_DIV) @(negedge CLK);
            vectors++;
            if (SEG !== es[s]) begin
                errors++;
                $display("FAIL lzb_0000_digit%0d SEG=%h required %h", s, SEG, es[s]);
            end
        end
    endtask

    task automatic test_latest_wins();
        drive_load(16'h1111, 4'h0, 4'h0, 1'b0);
        repeat (5) @(negedge CLK);
        drive_load(16'h2222, 4'h0, 4'h0, 1'b0);
        sync_frame();
        for (int s = 0; s < NDIG; s++) begin
            repeat (s == 0 ? 513 : SCAN_DIV) @(negedge CLK);
            vectors++;
            if (SEG !== 8'hA4) begin
                errors++;
                $display("FAIL latest_digit%0d SEG=%h required A4", s, SEG);
            end
        end
    endtask

    task automatic test_load_on_frame();
        sync_frame();
        drive_load(16'h4444, 4'h0, 4'h0, 1'b0);
        repeat (FRAME_LEN - 2) @(negedge CLK);
        drive_load(16'h5555, 4'h0, 4'h0, 1'b0);
        vectors++;
        if (FRAME !== 1'b1 || READY !== 1'b0) begin
            errors++;
            $display("FAIL wrap_load FRAME=%b READY=%b required 1/0", FRAME, READY);
        end
        repeat (513) @(negedge CLK);
        vectors++;
        if (SEG !== 8'h99 || DIGIT !== 4'b1110 || READY !== 1'b0) begin
            errors++;
            $display("FAIL wrap_prior_commit SEG=%h DIGIT=%b READY=%b required 99/1110/0", SEG, DIGIT, READY);
        end
        sync_frame();
        vectors++;
        if (READY !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ready READY=%b required 1", READY);
        end
        repeat (513) @(negedge CLK);
        vectors++;
        if (SEG !== 8'h92) begin
            errors++;
            $display("FAIL wrap_new_commit SEG=%h required 92", SEG);
        end
    endtask

    task automatic test_guard();
        int pos;
        logic ok;
        sync_frame();
        for (int k = 1; k <= FRAME_LEN; k++) begin
            @(negedge CLK);
            pos = (k - 1) % SCAN_DIV;
            ok = ($countones(~DIGIT) <= 1);
            if (pos < GUARD)
                ok = ok && DIGIT === 4'hF && SEG === 8'hFF;
`ifndef SEG_DIM_EN
            else
                ok = ok && $countones(~DIGIT) == 1;
`endif
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL guard pos=%0d SEG=%h DIGIT=%b", pos, SEG, DIGIT);
            end
        end
    endtask

`ifdef SEG_DIM_EN
    task automatic test_dim();
        int cnt, first, last;
        sync_frame();
        BRIGHT = 4'd7;
        repeat (SCAN_DIV) @(negedge CLK);
        cnt = 0; first = -1; last = -1;
        for (int p = 0; p < SCAN_DIV; p++) begin
            @(negedge CLK);
            if (DIGIT !== 4'hF) begin
                cnt++;
                if (first < 0) first = p;
                last = p;
            end
        end
        BRIGHT = 4'hF;
        vectors++;
        if (cnt != 510 || first != 4 || last != 513) begin
            errors++;
            $display("FAIL dim_b7 on=%0d first=%0d last=%0d required 510/4/513", cnt, first, last);
        end
    endtask
`endif

    task automatic test_random();
        int wait_n;
        for (int it = 0; it < 8 + 1; it++) begin
            wait_n = (it == 8) ? FRAME_LEN + 16 : $urandom_range(1500, 50);
            for (int c = 0; c < wait_n; c++) begin
                D = 16'($urandom); DP = 4'($urandom); BLANK = 4'($urandom); LZB = 1'($urandom);
`ifdef SEG_DIM_EN
                BRIGHT = 4'($urandom);
`endif
                @(negedge CLK);
                vectors++;
                if (SEG !== exp_seg || DIGIT !== exp_dig || READY !== exp_ready || FRAME !== exp_frame) begin
                    errors++;
                    $display("FAIL random_scan t=%0t SEG=%h DIGIT=%b READY=%b FRAME=%b required %h/%b/%b/%b",
                             $time, SEG, DIGIT, READY, FRAME, exp_seg, exp_dig, exp_ready, exp_frame);
                end
            end
            if (it < 8) begin
                drive_load(16'($urandom), 4'($urandom), 4'($urandom & 32'h5), 1'($urandom));
                if ($urandom_range(1, 0) == 1)
                    drive_load(16'($urandom) & 16'h00FF, 4'($urandom), 4'h0, 1'b1);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_display();
        test_lzb();
        test_latest_wins();
        test_load_on_frame();
        test_guard();
`ifdef SEG_DIM_EN
        test_dim();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
